imm_gen_pipe: RTL

- Parametrised, pipelined successor to the single-cycle immediate extender.
- Takes a full 32-bit RISC-V instruction over a valid/ready handshake and decodes the format from the opcode.
- Produces the XLEN-wide sign-extended immediate, the format code and an illegal flag through a registered 2-entry output buffer.
- Sits between fetch/decode and the execute operand mux.

---
 rtl/imm_gen_pkg.sv | 60 ++++++
 rtl/imm_buf.sv | 77 +++++++
 rtl/imm_gen_pipe.sv | 113 +++++++++++
 3 files changed

// File: rtl/imm_gen_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : imm_gen_pkg
//  Purpose  : Shared types and helpers for the pipelined immediate generator.
//             Holds the immediate format enum, the RISC-V major opcode
//             constants and the opcode -> {format, illegal} decode function.
//  Revision : 1.0  initial release
// ============================================================================
package imm_gen_pkg;

   typedef enum logic [2:0] {
      FMT_R    = 3'd0,
      FMT_I    = 3'd1,
      FMT_S    = 3'd2,
      FMT_B    = 3'd3,
      FMT_U    = 3'd4,
      FMT_J    = 3'd5,
      FMT_NONE = 3'd7
   } imm_fmt_t;

   localparam logic [6:0] OPC_OP        = 7'b0110011;
   localparam logic [6:0] OPC_LOAD      = 7'b0000011;
   localparam logic [6:0] OPC_OP_IMM    = 7'b0010011;
   localparam logic [6:0] OPC_JALR      = 7'b1100111;
   localparam logic [6:0] OPC_SYSTEM    = 7'b1110011;
   localparam logic [6:0] OPC_STORE     = 7'b0100011;
   localparam logic [6:0] OPC_BRANCH    = 7'b1100011;
   localparam logic [6:0] OPC_LUI       = 7'b0110111;
   localparam logic [6:0] OPC_AUIPC     = 7'b0010111;
   localparam logic [6:0] OPC_JAL       = 7'b1101111;
   localparam logic [6:0] OPC_OP_IMM_32 = 7'b0011011;
   localparam logic [6:0] OPC_OP_32     = 7'b0111011;

   typedef struct packed {
      imm_fmt_t fmt;
      logic     illegal;
   } dec_t;

   // The *W opcodes only exist on RV64; on RV32 they fall through to illegal.
   function automatic dec_t decode_opc(input logic [6:0] opc, input logic rv64);
      dec_t d;
      d.fmt     = FMT_NONE;
      d.illegal = 1'b0;
      case (opc)
         OPC_OP:                                      d.fmt = FMT_R;
         OPC_LOAD, OPC_OP_IMM, OPC_JALR, OPC_SYSTEM:  d.fmt = FMT_I;
         OPC_STORE:                                   d.fmt = FMT_S;
         OPC_BRANCH:                                  d.fmt = FMT_B;
         OPC_LUI, OPC_AUIPC:                          d.fmt = FMT_U;
         OPC_JAL:                                     d.fmt = FMT_J;
         OPC_OP_IMM_32: if (rv64)                     d.fmt = FMT_I;
         OPC_OP_32:     if (rv64)                     d.fmt = FMT_R;
         default:                                     d.fmt = FMT_NONE;
      endcase
      if (d.fmt == FMT_NONE) d.illegal = 1'b1;
      return d;
   endfunction

endpackage
`default_nettype wire

// File: rtl/imm_buf.sv
`default_nettype none
// ============================================================================
//  Module   : imm_buf
//  Purpose  : Generic BUF_DEPTH x WIDTH synchronous FIFO, valid/ready on both
//             sides, no same-cycle pass-through from out_ready to in_ready.
//  Ports    : clk, rst (async, active-high)
//             in_valid/in_ready/in_data   - write side
//             out_valid/out_ready/out_data - read side (head entry)
//  Revision : 1.0  initial release
// ============================================================================
module imm_buf #(
   parameter int BUF_DEPTH = 2,
   parameter int WIDTH     = 36
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_data,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out_data
);

   localparam int PTR_W = $clog2(BUF_DEPTH);
   localparam int CNT_W = $clog2(BUF_DEPTH + 1);

   logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
   logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
   logic [CNT_W-1:0] count_q,  count_d;
   logic [WIDTH-1:0] mem_q [BUF_DEPTH];
   logic [WIDTH-1:0] mem_d [BUF_DEPTH];
   logic             push, pop;

   // Ready is held low during reset so nothing is accepted while rst is high.
   assign in_ready  = ~rst && (count_q < CNT_W'(BUF_DEPTH));
   assign out_valid = (count_q != '0);
   assign out_data  = mem_q[rd_ptr_q];

   assign push = in_valid  & in_ready;
   assign pop  = out_valid & out_ready;

   always_comb begin
      rd_ptr_d = rd_ptr_q;
      wr_ptr_d = wr_ptr_q;
      count_d  = count_q;
      mem_d    = mem_q;
      if (push) begin
         mem_d[wr_ptr_q] = in_data;
         wr_ptr_d = (wr_ptr_q == PTR_W'(BUF_DEPTH - 1)) ? '0 : wr_ptr_q + PTR_W'(1);
      end
      if (pop) begin
         rd_ptr_d = (rd_ptr_q == PTR_W'(BUF_DEPTH - 1)) ? '0 : rd_ptr_q + PTR_W'(1);
      end
      case ({push, pop})
         2'b10:   count_d = count_q + CNT_W'(1);
         2'b01:   count_d = count_q - CNT_W'(1);
         default: count_d = count_q;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rd_ptr_q <= '0;
         wr_ptr_q <= '0;
         count_q  <= '0;
         for (int i = 0; i < BUF_DEPTH; i++) mem_q[i] <= '0;
      end else begin
         rd_ptr_q <= rd_ptr_d;
         wr_ptr_q <= wr_ptr_d;
         count_q  <= count_d;
         mem_q    <= mem_d;
      end
   end

endmodule
`default_nettype wire

// File: rtl/imm_gen_pipe.sv
`default_nettype none
// ============================================================================
//  Module   : imm_gen_pipe
//  Purpose  : Pipelined RISC-V immediate generator. Decodes the instruction
//             format from the opcode, builds the XLEN-wide sign-extended
//             immediate and buffers {imm, fmt, illegal} in imm_buf.
//  Ports    : clk, rst (async, active-high)
//             in_valid/in_ready/in_instr[31:0]            - instruction input
//             out_valid/out_ready/out_imm/out_fmt/out_illegal - head entry
//             err_cnt[15:0] - saturating illegal-opcode count
//                             (present only when IMM_GEN_ERR_CNT_EN is defined)
//  Params   : XLEN (32 or 64), BUF_DEPTH (2..4)
//  Revision : 1.0  initial release
// ============================================================================
module imm_gen_pipe
   import imm_gen_pkg::*;
#(
   parameter int XLEN      = 32,
   parameter int BUF_DEPTH = 2
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            in_valid,
   output logic            in_ready,
   input  logic [31:0]     in_instr,
   output logic            out_valid,
   input  logic            out_ready,
   output logic [XLEN-1:0] out_imm,
   output imm_fmt_t        out_fmt,
   output logic            out_illegal
`ifdef IMM_GEN_ERR_CNT_EN
   ,
   output logic [15:0]     err_cnt
`endif
);

   localparam int W = XLEN + 4;

   if (XLEN != 32 && XLEN != 64) begin : g_bad_xlen
      $error("imm_gen_pipe: XLEN must be 32 or 64");
   end
   if (BUF_DEPTH < 2 || BUF_DEPTH > 4) begin : g_bad_depth
      $error("imm_gen_pipe: BUF_DEPTH must be in 2..4");
   end

   dec_t            dec;
   logic [31:0]     imm32;
   logic [XLEN-1:0] imm_ext;
   logic            has_imm;
   logic [W-1:0]    buf_in, buf_out;
   logic            buf_valid;

   always_comb begin
      dec   = decode_opc(in_instr[6:0], XLEN == 64);
      imm32 = '0;
      case (dec.fmt)
         FMT_I: imm32 = {{20{in_instr[31]}}, in_instr[31:20]};
         FMT_S: imm32 = {{20{in_instr[31]}}, in_instr[31:25], in_instr[11:7]};
         FMT_B: imm32 = {{19{in_instr[31]}}, in_instr[31], in_instr[7],
                         in_instr[30:25], in_instr[11:8], 1'b0};
         FMT_U: imm32 = {in_instr[31:12], 12'b0};
         FMT_J: imm32 = {{11{in_instr[31]}}, in_instr[31], in_instr[19:12],
                         in_instr[20], in_instr[30:21], 1'b0};
         default: imm32 = '0;
      endcase
      // R-type and illegal carry no immediate, so bit 31 must not leak into
      // the upper fill for them.
      has_imm = (dec.fmt != FMT_R) && (dec.fmt != FMT_NONE);
      imm_ext = {XLEN{has_imm & in_instr[31]}};
      imm_ext[31:0] = imm32;
   end

   assign buf_in = {imm_ext, dec.fmt, dec.illegal};

   imm_buf #(
      .BUF_DEPTH (BUF_DEPTH),
      .WIDTH     (W)
   ) u_buf (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_data   (buf_in),
      .out_valid (buf_valid),
      .out_ready (out_ready),
      .out_data  (buf_out)
   );

   // Empty buffer presents the reset values rather than stale storage.
   assign out_valid   = buf_valid;
   assign out_imm     = buf_valid ? buf_out[W-1:4] : '0;
   assign out_fmt     = buf_valid ? imm_fmt_t'(buf_out[3:1]) : FMT_NONE;
   assign out_illegal = buf_valid & buf_out[0];

`ifdef IMM_GEN_ERR_CNT_EN
   logic [15:0] err_cnt_q, err_cnt_d;

   always_comb begin
      err_cnt_d = err_cnt_q;
      if (in_valid && in_ready && dec.illegal && (err_cnt_q != 16'hFFFF))
         err_cnt_d = err_cnt_q + 16'd1;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) err_cnt_q <= '0;
      else     err_cnt_q <= err_cnt_d;
   end

   assign err_cnt = err_cnt_q;
`endif

endmodule
`default_nettype wire
